// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of the buffered UART transmitter: byte push plus FIFO status and serial line.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 3
) ();
  logic               wr_en;
  logic [7:0]         wr_data;
  logic               full;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               busy;
  logic               tx;

  modport master (
    output wr_en, wr_data,
    input  full, count, overflow, busy, tx
  );

  modport slave (
    input  wr_en, wr_data,
    output full, count, overflow, busy, tx
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes pushed into a small FIFO are serialised back-to-back
// on tx with an internal baud divider.
module uart_tx_fifo #(
  parameter int CLK_DIV = 5208,
  parameter int FIFO_AW = 3
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = $clog2(CLK_DIV);
  localparam logic [BW-1:0]    DIV_M1  = BW'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             overflow_q;
  state_t           state_q;
  logic [BW-1:0]    baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic [FIFO_AW:0] count_w;
  logic             full_w;
  logic             baud_zero_w;
  logic             push_w;
  logic             pop_w;
  logic [7:0]       head_w;

  // full is judged on the registered pointers, so a pop in the same cycle cannot make room.
  always_comb begin
    count_w     = wr_ptr_q - rd_ptr_q;
    full_w      = (count_w == DEPTH_C);
    baud_zero_w = (baud_q == '0);
    push_w      = bus.wr_en && !full_w;
    pop_w       = (count_w != '0) &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_zero_w));
    head_w      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    wr_ptr_d    = push_w ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop_w  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (bus.wr_en && full_w) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop_w) begin
            shift_q <= head_w;
            baud_q  <= DIV_M1;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_zero_w) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            baud_q  <= DIV_M1;
            bit_q   <= '0;
            state_q <= S_DATA;
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_zero_w) begin
            baud_q <= DIV_M1;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        S_STOP: begin
          if (baud_zero_w) begin
            // Chain straight into the next start bit when more data is waiting.
            if (pop_w) begin
              shift_q <= head_w;
              baud_q  <= DIV_M1;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.full     = full_w;
  assign bus.count    = count_w;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q != S_IDLE) || (count_w != '0);
  assign bus.tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line decoder recovers frames from tx and each
// scenario compares them, plus status outputs, against expectations built from the frame rules.
module tb_uart_tx_fifo;
  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 3;
  localparam int FRAME   = 10 * CLK_DIV;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       ok;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   rst_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  frame_t mon_q[$];

  uart_tx_fifo_if #(.FIFO_AW(FIFO_AW)) bus ();

  uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  // Line decoder: samples mid-bit; frames interrupted by reset are discarded.
  initial begin
    int s;
    int rc;
    logic [7:0] d;
    logic st_ok;
    forever begin
      @(negedge clk);
      if (bus.tx === 1'b0 && rst === 1'b0) begin
        s  = cyc;
        rc = rst_cnt;
        repeat (CLK_DIV / 2) @(negedge clk);
        st_ok = (bus.tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          d[i] = bus.tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        st_ok = st_ok && (bus.tx === 1'b1);
        if (rst_cnt == rc) begin
          mon_q.push_back('{data: d, start: s, ok: st_ok});
          $display("frame: data=%02h start_cycle=%0d framing_ok=%0b", d, s, st_ok);
        end
      end
    end
  end

  // Expected tx level k clocks after the edge that accepted a push into an idle, empty FIFO.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int idx;
    idx = (k - 1) / CLK_DIV;
    if (k < 1 || idx >= 9) return 1'b1;
    if (idx == 0) return 1'b0;
    return b[idx-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_q.delete();
  endtask

  task automatic test_reset();
    int hi;
    do_reset();
    n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.tx === 1'b1) hi++;
    end
    n_checks++; if (hi !== 100) begin n_fail++; $display("FAIL idle_tx_high got=%0d exp=100 cycles", hi); end
    n_checks++; if (mon_q.size() !== 0) begin n_fail++; $display("FAIL idle_frames got=%0d exp=0", mon_q.size()); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    do_reset();
    b = 8'h55;
    bus.wr_data = b;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    n_checks++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL single_count0 got=%0d exp=1", bus.count); end
    for (int k = 1; k <= 41; k++) begin
      tick();
      n_checks++;
      if (bus.tx !== exp_tx(b, k)) begin
        n_fail++; $display("FAIL single_tx k=%0d got=%b exp=%b", k, bus.tx, exp_tx(b, k));
      end
      n_checks++;
      if (bus.busy !== (k < 41)) begin
        n_fail++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, bus.busy, (k < 41));
      end
      if (k == 1) begin
        n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL single_count1 got=%0d exp=0", bus.count); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int p;
    do_reset();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA3;
    tick();
    p = cyc;
    bus.wr_data = 8'h0F;
    tick();
    bus.wr_en = 1'b0;
    repeat (2 * FRAME + 10) tick();
    n_checks++;
    if (mon_q.size() !== 2) begin
      n_fail++; $display("FAIL b2b_frames got=%0d exp=2", mon_q.size());
    end else begin
      n_checks++; if (mon_q[0].data !== 8'hA3) begin n_fail++; $display("FAIL b2b_data0 got=%02h exp=a3", mon_q[0].data); end
      n_checks++; if (mon_q[1].data !== 8'h0F) begin n_fail++; $display("FAIL b2b_data1 got=%02h exp=0f", mon_q[1].data); end
      n_checks++; if (mon_q[0].start !== p + 1) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", mon_q[0].start, p + 1); end
      n_checks++;
      if (mon_q[1].start - mon_q[0].start !== FRAME) begin
        n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", mon_q[1].start - mon_q[0].start, FRAME);
      end
      n_checks++; if (!(mon_q[0].ok && mon_q[1].ok)) begin n_fail++; $display("FAIL b2b_framing got=%b%b exp=11", mon_q[0].ok, mon_q[1].ok); end
    end
  endtask

  task automatic test_fill_overflow();
    int ec;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      tick();
      ec = (i == 0) ? 1 : ((i > 8) ? 8 : i);
      n_checks++; if (bus.count !== 4'(ec)) begin n_fail++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, bus.count, ec); end
      n_checks++; if (bus.full !== (ec == 8)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.full, (ec == 8)); end
      n_checks++; if (bus.overflow !== (i == 9)) begin n_fail++; $display("FAIL fill_overflow i=%0d got=%b exp=%b", i, bus.overflow, (i == 9)); end
    end
    bus.wr_en = 1'b0;
    repeat (41 - 9) tick();
    n_checks++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL fill_count_frame2 got=%0d exp=7", bus.count); end
    repeat (9 * FRAME) tick();
    n_checks++;
    if (mon_q.size() !== 9) begin
      n_fail++; $display("FAIL fill_frames got=%0d exp=9", mon_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (mon_q[i].data !== 8'(i) || !mon_q[i].ok) begin
          n_fail++; $display("FAIL fill_data i=%0d got=%02h ok=%b exp=%02h", i, mon_q[i].data, mon_q[i].ok, i);
        end
      end
    end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_sticky got=%b exp=1", bus.overflow); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h10 + 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (40 - 8) tick();
    n_checks++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ppf_pre got=count %0d ovf %b exp=count 8 ovf 0", bus.count, bus.overflow); end
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hC4;
    tick();
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ppf_overflow got=%b exp=1", bus.overflow); end
    n_checks++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL ppf_count_pop got=%0d exp=7", bus.count); end
    tick();
    bus.wr_en = 1'b0;
    n_checks++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin n_fail++; $display("FAIL ppf_retry got=count %0d full %b exp=count 8 full 1", bus.count, bus.full); end
    repeat (9 * FRAME + 10) tick();
    n_checks++;
    if (mon_q.size() !== 10) begin
      n_fail++; $display("FAIL ppf_frames got=%0d exp=10", mon_q.size());
    end else begin
      n_checks++; if (mon_q[8].data !== 8'h18) begin n_fail++; $display("FAIL ppf_data8 got=%02h exp=18", mon_q[8].data); end
      n_checks++; if (mon_q[9].data !== 8'hC4) begin n_fail++; $display("FAIL ppf_data9 got=%02h exp=c4", mon_q[9].data); end
    end
  endtask

  task automatic test_reset_midframe();
    int hi;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'hE0 + 8'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (bus.tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx got=%b exp=1", bus.tx); end
    n_checks++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", bus.count); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.tx === 1'b1) hi++;
    end
    n_checks++; if (hi !== 100) begin n_fail++; $display("FAIL midrst_quiet got=%0d exp=100 cycles", hi); end
    n_checks++; if (mon_q.size() !== 0) begin n_fail++; $display("FAIL midrst_frames got=%0d exp=0", mon_q.size()); end
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h81;
    tick();
    bus.wr_en = 1'b0;
    repeat (FRAME + 5) tick();
    n_checks++;
    if (mon_q.size() !== 1 || mon_q[0].data !== 8'h81 || !mon_q[0].ok) begin
      n_fail++; $display("FAIL midrst_fresh got=%0d frames exp=1 frame of 81", mon_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int n;
    int gap;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      exp_q.delete();
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        gap = $urandom_range(0, 20);
        repeat (gap) tick();
        b = 8'($urandom);
        exp_q.push_back(b);
        bus.wr_en = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en = 1'b0;
      end
      repeat (n * FRAME + 20) tick();
      n_checks++;
      if (mon_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand_frames it=%0d got=%0d exp=%0d", it, mon_q.size(), exp_q.size());
      end else begin
        for (int j = 0; j < n; j++) begin
          n_checks++;
          if (mon_q[j].data !== exp_q[j] || !mon_q[j].ok) begin
            n_fail++; $display("FAIL rand_data it=%0d j=%0d got=%02h exp=%02h", it, j, mon_q[j].data, exp_q[j]);
          end
          if (j > 0) begin
            n_checks++;
            if (mon_q[j].start - mon_q[j-1].start < FRAME) begin
              n_fail++; $display("FAIL rand_spacing it=%0d j=%0d got=%0d exp>=%0d", it, j, mon_q[j].start - mon_q[j-1].start, FRAME);
            end
          end
        end
      end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rand_idle it=%0d got=%b exp=0", it, bus.busy); end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_push_pop_full();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
